// File: rtl/sc_game_sequencer.sv
// Game-flow controller for Frogger: lives, level and homes-filled counters,
// a timed level-start banner and a pause mode that can freeze the banner or play.
module sc_game_sequencer #(
  parameter int NUM_LIVES   = 3,
  parameter int NUM_LEVELS  = 5,
  parameter int NUM_HOMES   = 5,
  parameter int START_DELAY = 50,
  localparam int LW = $clog2(NUM_LIVES + 1),
  localparam int VW = $clog2(NUM_LEVELS + 1),
  localparam int HW = $clog2(NUM_HOMES + 1)
) (
  input  logic          SC_GAMESEQ_CLOCK_50,
  input  logic          SC_GAMESEQ_RESET_InHigh,
  input  logic          SC_GAMESEQ_startButton_InLow,
  input  logic          SC_GAMESEQ_pauseButton_InLow,
  input  logic          SC_GAMESEQ_frogDies_InLow,
  input  logic          SC_GAMESEQ_frogHome_InLow,
  output logic          SC_GAMESEQ_Load_OutLow,
  output logic          SC_GAMESEQ_FrogReset_OutLow,
  output logic          SC_GAMESEQ_HomeLatch_OutLow,
  output logic          SC_GAMESEQ_Run_Out,
  output logic          SC_GAMESEQ_Win_Out,
  output logic          SC_GAMESEQ_GameOver_Out,
  output logic [LW-1:0] SC_GAMESEQ_Lives,
  output logic [VW-1:0] SC_GAMESEQ_Level,
  output logic [HW-1:0] SC_GAMESEQ_Homes,
  output logic [3:0]    SC_GAMESEQ_State
);

  localparam int DW = $clog2(START_DELAY + 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_START   = 4'd1,
    S_LOAD    = 4'd2,
    S_DELAY   = 4'd3,
    S_PLAY    = 4'd4,
    S_DIE     = 4'd5,
    S_HOME    = 4'd6,
    S_LEVELUP = 4'd7,
    S_PAUSE   = 4'd8,
    S_WIN     = 4'd9,
    S_LOSE    = 4'd10
  } state_t;

  state_t        state, next_state, ret_state;
  logic          start_prev, pause_prev;
  logic          start_press, pause_press;
  logic [DW-1:0] dcnt;
  logic [LW-1:0] lives;
  logic [VW-1:0] level;
  logic [HW-1:0] homes;

  // A press is the first cycle the button reads low; holding it counts once.
  assign start_press = !SC_GAMESEQ_startButton_InLow && start_prev;
  assign pause_press = !SC_GAMESEQ_pauseButton_InLow && pause_prev;

  // Previous-value registers for the two button edge detectors.
  always_ff @(posedge SC_GAMESEQ_CLOCK_50 or posedge SC_GAMESEQ_RESET_InHigh) begin
    if (SC_GAMESEQ_RESET_InHigh) begin
      start_prev <= 1'b1;
      pause_prev <= 1'b1;
    end else begin
      start_prev <= SC_GAMESEQ_startButton_InLow;
      pause_prev <= SC_GAMESEQ_pauseButton_InLow;
    end
  end

  // State register; the state that entered PAUSE is remembered for the return.
  always_ff @(posedge SC_GAMESEQ_CLOCK_50 or posedge SC_GAMESEQ_RESET_InHigh) begin
    if (SC_GAMESEQ_RESET_InHigh) begin
      state     <= S_IDLE;
      ret_state <= S_PLAY;
    end else begin
      state <= next_state;
      if (next_state == S_PAUSE && state != S_PAUSE) ret_state <= state;
    end
  end

  // Next-state decode; in PLAY pause beats death, death beats home.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    next_state = S_START;
      S_START:   if (start_press) next_state = S_LOAD;
      S_LOAD:    next_state = S_DELAY;
      S_DELAY: begin
        if (pause_press) next_state = S_PAUSE;
        else if (dcnt == DW'(START_DELAY - 1)) next_state = S_PLAY;
      end
      S_PLAY: begin
        if (pause_press) next_state = S_PAUSE;
        else if (!SC_GAMESEQ_frogDies_InLow) next_state = S_DIE;
        else if (!SC_GAMESEQ_frogHome_InLow) next_state = S_HOME;
      end
      S_DIE:     next_state = (lives <= LW'(1)) ? S_LOSE : S_PLAY;
      S_HOME:    next_state = (homes >= HW'(NUM_HOMES - 1)) ? S_LEVELUP : S_PLAY;
      S_LEVELUP: next_state = (level >= VW'(NUM_LEVELS)) ? S_WIN : S_LOAD;
      S_PAUSE:   if (pause_press) next_state = ret_state;
      S_WIN, S_LOSE: if (start_press) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Game counters and banner counter; updated as each state is left, frozen in PAUSE.
  always_ff @(posedge SC_GAMESEQ_CLOCK_50 or posedge SC_GAMESEQ_RESET_InHigh) begin
    if (SC_GAMESEQ_RESET_InHigh) begin
      lives <= LW'(NUM_LIVES);
      level <= VW'(1);
      homes <= '0;
      dcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          lives <= LW'(NUM_LIVES);
          level <= VW'(1);
          homes <= '0;
        end
        S_DELAY:   if (!pause_press) dcnt <= dcnt + DW'(1);
        S_DIE:     if (lives != '0) lives <= lives - LW'(1);
        S_HOME:    if (homes < HW'(NUM_HOMES)) homes <= homes + HW'(1);
        S_LEVELUP: if (level < VW'(NUM_LEVELS)) level <= level + VW'(1);
        default: ;
      endcase
      // Entering LOAD starts a fresh level: empty homes, banner restarts.
      if (next_state == S_LOAD) begin
        homes <= '0;
        dcnt  <= '0;
      end
    end
  end

  // Moore output decode from state and counters only.
  always_comb begin
    SC_GAMESEQ_Load_OutLow      = 1'b1;
    SC_GAMESEQ_FrogReset_OutLow = 1'b1;
    SC_GAMESEQ_HomeLatch_OutLow = 1'b1;
    SC_GAMESEQ_Run_Out          = 1'b0;
    SC_GAMESEQ_Win_Out          = 1'b0;
    SC_GAMESEQ_GameOver_Out     = 1'b0;
    case (state)
      S_LOAD: begin
        SC_GAMESEQ_Load_OutLow      = 1'b0;
        SC_GAMESEQ_FrogReset_OutLow = 1'b0;
      end
      S_DIE:  SC_GAMESEQ_FrogReset_OutLow = 1'b0;
      S_HOME: begin
        SC_GAMESEQ_HomeLatch_OutLow = 1'b0;
        SC_GAMESEQ_FrogReset_OutLow = 1'b0;
      end
      S_PLAY: SC_GAMESEQ_Run_Out      = 1'b1;
      S_WIN:  SC_GAMESEQ_Win_Out      = 1'b1;
      S_LOSE: SC_GAMESEQ_GameOver_Out = 1'b1;
      default: ;
    endcase
  end

  assign SC_GAMESEQ_Lives = lives;
  assign SC_GAMESEQ_Level = level;
  assign SC_GAMESEQ_Homes = homes;
  assign SC_GAMESEQ_State = state;

endmodule

// File: tb/tb_sc_game_sequencer.sv
// Bench for sc_game_sequencer with a short banner (START_DELAY=4).
module tb_sc_game_sequencer;

  localparam int NUM_LIVES   = 3;
  localparam int NUM_LEVELS  = 5;
  localparam int NUM_HOMES   = 5;
  localparam int START_DELAY = 4;
  localparam int LW = $clog2(NUM_LIVES + 1);
  localparam int VW = $clog2(NUM_LEVELS + 1);
  localparam int HW = $clog2(NUM_HOMES + 1);
  localparam int EW = 4 + LW + VW + HW + 6;

  localparam logic [3:0] S_IDLE = 4'd0, S_START = 4'd1, S_LOAD = 4'd2, S_DELAY = 4'd3,
                         S_PLAY = 4'd4, S_DIE = 4'd5, S_HOME = 4'd6, S_LEVELUP = 4'd7,
                         S_PAUSE = 4'd8, S_WIN = 4'd9, S_LOSE = 4'd10;

  // Table row: buttons/detectors as "held down" flags, then expected post-edge state.
  typedef struct packed {
    logic s, p, d, h;
    logic [3:0]    st;
    logic [LW-1:0] lv;
    logic [VW-1:0] lvl;
    logic [HW-1:0] hm;
  } vec_t;

  logic clk, rst;
  logic start_btn, pause_btn, dies, home;
  logic load, frog_reset, home_latch, run, win, game_over;
  logic [LW-1:0] lives;
  logic [VW-1:0] level;
  logic [HW-1:0] homes;
  logic [3:0]    state;

  logic [EW-1:0] exp_q[$];
  vec_t vecs[$];
  int n_cmp, n_err;

  sc_game_sequencer #(
    .NUM_LIVES(NUM_LIVES), .NUM_LEVELS(NUM_LEVELS),
    .NUM_HOMES(NUM_HOMES), .START_DELAY(START_DELAY)
  ) dut (
    .SC_GAMESEQ_CLOCK_50(clk),
    .SC_GAMESEQ_RESET_InHigh(rst),
    .SC_GAMESEQ_startButton_InLow(start_btn),
    .SC_GAMESEQ_pauseButton_InLow(pause_btn),
    .SC_GAMESEQ_frogDies_InLow(dies),
    .SC_GAMESEQ_frogHome_InLow(home),
    .SC_GAMESEQ_Load_OutLow(load),
    .SC_GAMESEQ_FrogReset_OutLow(frog_reset),
    .SC_GAMESEQ_HomeLatch_OutLow(home_latch),
    .SC_GAMESEQ_Run_Out(run),
    .SC_GAMESEQ_Win_Out(win),
    .SC_GAMESEQ_GameOver_Out(game_over),
    .SC_GAMESEQ_Lives(lives),
    .SC_GAMESEQ_Level(level),
    .SC_GAMESEQ_Homes(homes),
    .SC_GAMESEQ_State(state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe/flag table: {load, frog_reset, home_latch, run, win, game_over}.
  function automatic logic [5:0] flags_of(input logic [3:0] st);
    case (st)
      S_LOAD:  return 6'b001000;
      S_DIE:   return 6'b101000;
      S_HOME:  return 6'b100000;
      S_PLAY:  return 6'b111100;
      S_WIN:   return 6'b111010;
      S_LOSE:  return 6'b111001;
      default: return 6'b111000;
    endcase
  endfunction

  function automatic logic [EW-1:0] pack_exp(input logic [3:0] st, input int lv, input int lvl,
                                             input int hm);
    return {st, LW'(lv), VW'(lvl), HW'(hm), flags_of(st)};
  endfunction

  function automatic vec_t mk(input logic s, input logic p, input logic d, input logic h,
                              input logic [3:0] st, input int lv, input int lvl, input int hm);
    vec_t v;
    v.s = s; v.p = p; v.d = d; v.h = h;
    v.st = st; v.lv = LW'(lv); v.lvl = VW'(lvl); v.hm = HW'(hm);
    return v;
  endfunction

  // Scoreboard: pop the oldest expectation and compare against the outputs now.
  task automatic check(input string name);
    logic [EW-1:0] act, exp_v;
    act = {state, lives, level, homes, load, frog_reset, home_latch, run, win, game_over};
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got st=%0d lv=%0d lvl=%0d hm=%0d flags=%b, expected st=%0d lv=%0d lvl=%0d hm=%0d flags=%b",
               name, act[EW-1 -: 4], lives, level, homes, act[5:0],
               exp_v[EW-1 -: 4], exp_v[EW-5 -: LW], exp_v[EW-5-LW -: VW],
               exp_v[HW+5 -: HW], exp_v[5:0]);
    end
  endtask

  // Driver: one clock with the given held-down inputs; expectation queued before the edge.
  task automatic cyc(input logic s, input logic p, input logic d, input logic h,
                     input logic [3:0] st, input int lv, input int lvl, input int hm,
                     input string name);
    @(negedge clk);
    start_btn = ~s; pause_btn = ~p; dies = ~d; home = ~h;
    exp_q.push_back(pack_exp(st, lv, lvl, hm));
    @(posedge clk);
    #1;
    check(name);
  endtask

  // Fill homes from 'from' up to a full level, then follow LEVELUP to LOAD/PLAY or WIN.
  task automatic do_homes(input int from, input int lvl, input bit last);
    for (int h = from; h < NUM_HOMES; h++) begin
      cyc(0, 0, 0, 1, S_HOME, 3, lvl, h, $sformatf("home_l%0d_h%0d", lvl, h));
      if (h < NUM_HOMES - 1)
        cyc(0, 0, 0, 0, S_PLAY, 3, lvl, h + 1, $sformatf("back_l%0d_h%0d", lvl, h));
      else
        cyc(0, 0, 0, 0, S_LEVELUP, 3, lvl, NUM_HOMES, $sformatf("levelup_l%0d", lvl));
    end
    if (last) begin
      cyc(0, 0, 0, 0, S_WIN, 3, lvl, NUM_HOMES, "win_no_load");
    end else begin
      cyc(0, 0, 0, 0, S_LOAD, 3, lvl + 1, 0, $sformatf("load_l%0d", lvl + 1));
      for (int i = 0; i < START_DELAY; i++)
        cyc(0, 0, 0, 0, S_DELAY, 3, lvl + 1, 0, $sformatf("delay_l%0d_%0d", lvl + 1, i));
      cyc(0, 0, 0, 0, S_PLAY, 3, lvl + 1, 0, $sformatf("play_l%0d", lvl + 1));
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    start_btn = 1'b1; pause_btn = 1'b1; dies = 1'b1; home = 1'b1;
    rst = 1'b1;
    #1;
    exp_q.push_back(pack_exp(S_IDLE, 3, 1, 0));
    check("reset_values");

    // Start-up, three deaths to LOSE, restart, pause/death race, held pause.
    vecs.push_back(mk(0, 0, 0, 0, S_START,  3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, S_START,  3, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, S_LOAD,   3, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, S_DELAY,  3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, S_DELAY,  3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, S_DELAY,  3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, S_DELAY,  3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, S_PLAY,   3, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, S_DIE,    3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, S_PLAY,   2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, S_PLAY,   2, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, S_DIE,    2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, S_PLAY,   1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, S_DIE,    1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, S_LOSE,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, S_LOSE,   0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, S_IDLE,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, S_START,  3, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, S_LOAD,   3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, S_DELAY,  3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, S_DELAY,  3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, S_DELAY,  3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, S_DELAY,  3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, S_PLAY,   3, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, S_PAUSE,  3, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, S_PAUSE,  3, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, S_PLAY,   3, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, S_HOME,   3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, S_PLAY,   3, 1, 1));

    @(posedge clk);
    #2 rst = 1'b0;
    foreach (vecs[i])
      cyc(vecs[i].s, vecs[i].p, vecs[i].d, vecs[i].h,
          vecs[i].st, int'(vecs[i].lv), int'(vecs[i].lvl), int'(vecs[i].hm),
          $sformatf("vec%0d", i));

    // Clear all five levels to WIN, then restart.
    do_homes(1, 1, 0);
    do_homes(0, 2, 0);
    do_homes(0, 3, 0);
    do_homes(0, 4, 0);
    do_homes(0, 5, 1);
    cyc(0, 0, 0, 0, S_WIN,   3, 5, NUM_HOMES, "win_hold");
    cyc(1, 0, 0, 0, S_IDLE,  3, 5, NUM_HOMES, "win_to_idle");
    cyc(0, 0, 0, 0, S_START, 3, 1, 0, "reinit_start");

    // Pause during the banner at count 2; deaths while paused are ignored.
    cyc(1, 0, 0, 0, S_LOAD,  3, 1, 0, "pd_load");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, S_DELAY, 3, 1, 0, $sformatf("pd_delay%0d", i));
    cyc(0, 1, 0, 0, S_PAUSE, 3, 1, 0, "pd_enter");
    for (int i = 0; i < 9; i++)
      cyc(0, 1, (i % 2 == 0), 0, S_PAUSE, 3, 1, 0, $sformatf("pd_hold%0d", i));
    cyc(0, 0, 1, 0, S_PAUSE, 3, 1, 0, "pd_release");
    cyc(0, 1, 0, 0, S_DELAY, 3, 1, 0, "pd_resume");
    cyc(0, 0, 0, 0, S_DELAY, 3, 1, 0, "pd_count3");
    cyc(0, 0, 0, 0, S_PLAY,  3, 1, 0, "pd_play");

    // Reset asserted while the HOME strobes are low.
    cyc(0, 0, 1, 0, S_DIE,  3, 1, 0, "rc_die");
    cyc(0, 0, 0, 0, S_PLAY, 2, 1, 0, "rc_play");
    cyc(0, 0, 0, 1, S_HOME, 2, 1, 0, "rc_home1");
    cyc(0, 0, 0, 0, S_PLAY, 2, 1, 1, "rc_play2");
    cyc(0, 0, 0, 1, S_HOME, 2, 1, 1, "rc_home2");
    #2 rst = 1'b1;
    #1;
    exp_q.push_back(pack_exp(S_IDLE, 3, 1, 0));
    check("async_reset_in_home");
    @(posedge clk);
    #2 rst = 1'b0;
    cyc(0, 0, 0, 0, S_START, 3, 1, 0, "after_reset_start");

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
